// File: rtl/rv32i_decode_stage.sv
// -----------------------------------------------------------------------------
// rv32i_decode_stage
//
// Purpose
//   Decode stage for an RV32I pipeline. The incoming instruction word is
//   decoded combinationally on the input side, and the decoded bundle is then
//   captured in flops. Storage is one output register plus one skid register.
//   This gives full throughput while the consumer is ready, and loses nothing
//   when backpressure arrives while an input is being offered.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous, active-high reset
//   in_valid     in   1   instruction offered
//   in_ready     out  1   stage can accept (registered, == !skid_full)
//   in_instr     in  32   RV32I instruction word
//   in_pc        in  32   instruction address
//   flush        in   1   discard every held instruction, drop current input
//   out_valid    out  1   decoded bundle valid
//   out_ready    in   1   consumer accepts
//   out_pc       out 32   passed-through pc
//   out_opcode   out  7   instr[6:0]
//   out_funct3   out  3   instr[14:12]
//   out_alu_op   out  6   ALU operation (alu_op_e encoding)
//   out_rd       out  5   destination register, 0 when not written
//   out_rs1      out  5   source register 1, 0 when not read
//   out_rs2      out  5   source register 2, 0 when not read
//   out_imm      out 32   sign-extended immediate
//   out_illegal  out  1   instruction not decodable
// -----------------------------------------------------------------------------
module rv32i_decode_stage (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,

    input  logic        flush,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [5:0]  out_alu_op,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic        out_illegal
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [5:0] {
        ALU_ADD     = 6'd0,
        ALU_SUB     = 6'd1,
        ALU_SLL     = 6'd2,
        ALU_SLT     = 6'd3,
        ALU_SLTU    = 6'd4,
        ALU_XOR     = 6'd5,
        ALU_SRL     = 6'd6,
        ALU_SRA     = 6'd7,
        ALU_OR      = 6'd8,
        ALU_AND     = 6'd9,
        ALU_ADDI    = 6'd10,
        ALU_SLTI    = 6'd11,
        ALU_SLTIU   = 6'd12,
        ALU_XORI    = 6'd13,
        ALU_ORI     = 6'd14,
        ALU_ANDI    = 6'd15,
        ALU_BYPASS  = 6'd16,
        ALU_JALR    = 6'd17,
        ALU_INVALID = 6'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } bundle_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    localparam bundle_t OUT_RESET = '{
        pc:      32'h0,
        opcode:  7'h0,
        funct3:  3'h0,
        alu_op:  ALU_INVALID,
        rd:      5'h0,
        rs1:     5'h0,
        rs2:     5'h0,
        imm:     32'h0,
        illegal: 1'b0
    };

    // -------------------------------------------------------------------------
    // Input-side decode (pure combinational, registered below)
    // -------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    fmt_e        dec_fmt;
    alu_op_e     dec_alu;
    logic        dec_legal;
    logic [31:0] dec_imm;
    bundle_t     dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // NOTE: every signal written in an always_comb gets a default on entry;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        dec_fmt   = FMT_R;
        dec_alu   = ALU_INVALID;
        dec_legal = 1'b1;

        case (opcode)
            OP_LUI: begin
                dec_fmt = FMT_U;
                dec_alu = ALU_BYPASS;
            end
            OP_AUIPC: begin
                dec_fmt = FMT_U;
                dec_alu = ALU_ADD;
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_alu = ALU_ADD;
            end
            OP_JALR: begin
                dec_fmt   = FMT_I;
                dec_alu   = ALU_JALR;
                dec_legal = (funct3 == 3'b000);
            end
            OP_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_alu   = ALU_SUB;
                dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_LOAD: begin
                dec_fmt   = FMT_I;
                dec_alu   = ALU_ADD;
                dec_legal = (funct3 == 3'b010);   // only LW exists here
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_alu   = ALU_ADD;
                dec_legal = (funct3 == 3'b010);   // only SW exists here
            end
            OP_IMM: begin
                dec_fmt = FMT_I;
                case (funct3)
                    3'b000: dec_alu = ALU_ADDI;
                    3'b001: begin
                        dec_alu   = ALU_SLL;
                        dec_legal = (funct7 == F7_BASE);
                    end
                    3'b010: dec_alu = ALU_SLTI;
                    3'b011: dec_alu = ALU_SLTIU;
                    3'b100: dec_alu = ALU_XORI;
                    3'b101: begin
                        // Shift-right immediates use funct7 to pick SRL/SRA.
                        if (funct7 == F7_BASE) begin
                            dec_alu = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_alu = ALU_SRA;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                    3'b110: dec_alu = ALU_ORI;
                    default: dec_alu = ALU_ANDI;  // 3'b111
                endcase
            end
            OP_REG: begin
                dec_fmt = FMT_R;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_alu = ALU_ADD;
                    {F7_BASE, 3'b001}: dec_alu = ALU_SLL;
                    {F7_BASE, 3'b010}: dec_alu = ALU_SLT;
                    {F7_BASE, 3'b011}: dec_alu = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec_alu = ALU_XOR;
                    {F7_BASE, 3'b101}: dec_alu = ALU_SRL;
                    {F7_BASE, 3'b110}: dec_alu = ALU_OR;
                    {F7_BASE, 3'b111}: dec_alu = ALU_AND;
                    {F7_ALT,  3'b000}: dec_alu = ALU_SUB;
                    {F7_ALT,  3'b101}: dec_alu = ALU_SRA;
                    default:           dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Immediate extraction by instruction format.
    always_comb begin
        dec_imm = 32'h0;
        case (dec_fmt)
            FMT_I: dec_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: dec_imm = {in_instr[31:12], 12'h000};
            FMT_J: dec_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm = 32'h0;  // R-type carries no immediate
        endcase
    end

    // Assemble the bundle; an illegal word keeps pc/opcode/funct3 for the
    // trap handler but zeroes every operand field.
    always_comb begin
        dec         = OUT_RESET;
        dec.pc      = in_pc;
        dec.opcode  = opcode;
        dec.funct3  = funct3;
        dec.illegal = !dec_legal;
        if (dec_legal) begin
            dec.alu_op = dec_alu;
            dec.imm    = dec_imm;
            dec.rd     = (dec_fmt != FMT_S && dec_fmt != FMT_B) ? in_instr[11:7]  : 5'd0;
            dec.rs1    = (dec_fmt != FMT_U && dec_fmt != FMT_J) ? in_instr[19:15] : 5'd0;
            dec.rs2    = (dec_fmt == FMT_R || dec_fmt == FMT_S || dec_fmt == FMT_B)
                         ? in_instr[24:20] : 5'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Output register + skid register handshake
    // -------------------------------------------------------------------------
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    out_free;
    logic    in_fire;
    logic    load_out_from_skid;
    logic    load_out_from_in;
    logic    load_skid;

    // The output slot can take new data when it is empty or draining now.
    assign out_free = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready_q;

    always_comb begin
        out_valid_d        = out_valid_q;
        skid_valid_d       = skid_valid_q;
        load_out_from_skid = 1'b0;
        load_out_from_in   = 1'b0;
        load_skid          = 1'b0;

        if (flush) begin
            // Flush outranks every transfer, including the one being offered.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older skid entry goes first; in_ready was low, so no input
                // can be arriving on this edge.
                load_out_from_skid = 1'b1;
                out_valid_d        = 1'b1;
                skid_valid_d       = 1'b0;
            end else if (in_fire) begin
                load_out_from_in = 1'b1;
                out_valid_d      = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output is held: park the newcomer in the skid slot.
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end

        // Registered ready: accept next cycle only if the skid will be empty.
        in_ready_d = !skid_valid_d;
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_q        <= OUT_RESET;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            if (load_out_from_skid) begin
                out_q <= skid_q;
            end else if (load_out_from_in) begin
                out_q <= dec;
            end
        end
    end

    // NOTE: the skid payload has no reset; skid_valid_q qualifies it, so
    // clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= dec;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs straight from flops
    // -------------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_alu_op  = out_q.alu_op;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_rv32i_decode_stage
//
// Directed checks of reset, decode examples, backpressure, flush and
// mid-transfer reset, followed by a randomized run scored against a
// queue-based reference model of the two-entry stage.
// -----------------------------------------------------------------------------
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [5:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [5:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    rv32i_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_alu_op  (out_alu_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"},   {31'd0, out_valid},   32'd1);
        check({tag, ".pc"},      out_pc,               e.pc);
        check({tag, ".opcode"},  {25'd0, out_opcode},  {25'd0, e.opcode});
        check({tag, ".funct3"},  {29'd0, out_funct3},  {29'd0, e.funct3});
        check({tag, ".alu_op"},  {26'd0, out_alu_op},  {26'd0, e.alu});
        check({tag, ".rd"},      {27'd0, out_rd},      {27'd0, e.rd});
        check({tag, ".rs1"},     {27'd0, out_rs1},     {27'd0, e.rs1});
        check({tag, ".rs2"},     {27'd0, out_rs2},     {27'd0, e.rs2});
        check({tag, ".imm"},     out_imm,              e.imm);
        check({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                                input int alu, input int rd, input int rs1, input int rs2,
                                input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.opcode = op; e.funct3 = f3; e.alu = 6'(alu);
        e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.imm = imm; e.ill = ill;
        return e;
    endfunction

    // Reference decoder: classify the instruction by format letter and look
    // up the ALU operation from per-funct3 tables.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        byte         fmt;
        int          alu;
        bit          ok;
        int          reg_ops[8];
        int          imm_ops[8];
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [11:0] i12;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        reg_ops = '{0, 2, 3, 4, 5, 6, 8, 9};
        imm_ops = '{10, 2, 11, 12, 13, 6, 14, 15};
        f7  = i[31:25];
        f3  = i[14:12];
        ok  = 1;
        alu = 18;
        fmt = "X";
        case (i[6:0])
            7'h37: begin fmt = "U"; alu = 16; end
            7'h17: begin fmt = "U"; alu = 0; end
            7'h6F: begin fmt = "J"; alu = 0; end
            7'h67: begin fmt = "I"; alu = 17; ok = (f3 == 0); end
            7'h63: begin fmt = "B"; alu = 1;  ok = !(f3 == 2 || f3 == 3); end
            7'h03: begin fmt = "I"; alu = 0;  ok = (f3 == 2); end
            7'h23: begin fmt = "S"; alu = 0;  ok = (f3 == 2); end
            7'h13: begin
                fmt = "I";
                alu = imm_ops[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) alu = 7;
                    else ok = (f7 == 0);
                end
            end
            7'h33: begin
                fmt = "R";
                if (f7 == 0) alu = reg_ops[f3];
                else if (f7 == 7'h20 && f3 == 0) alu = 1;
                else if (f7 == 7'h20 && f3 == 5) alu = 7;
                else ok = 0;
            end
            default: ok = 0;
        endcase
        i12 = i[31:20];
        s12 = {i[31:25], i[11:7]};
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.pc = pc; e.opcode = i[6:0]; e.funct3 = f3; e.ill = !ok;
        e.alu = 6'd18; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0;
        if (ok) begin
            e.alu = 6'(alu);
            case (fmt)
                "I": e.imm = 32'($signed(i12));
                "S": e.imm = 32'($signed(s12));
                "B": e.imm = 32'($signed(b13));
                "U": e.imm = {i[31:12], 12'h000};
                "J": e.imm = 32'($signed(j21));
                default: e.imm = 0;
            endcase
            if (fmt != "B" && fmt != "S") e.rd = i[11:7];
            if (fmt != "U" && fmt != "J") e.rs1 = i[19:15];
            if (fmt == "R" || fmt == "B" || fmt == "S") e.rs2 = i[24:20];
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  ops[9];
        int          sel;
        int          k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h13, 7'h23, 7'h33};
        r   = $urandom;
        sel = int'($urandom_range(0, 11));
        if (sel < 9) r[6:0] = ops[sel];
        k = int'($urandom_range(0, 3));
        if (k == 0) r[31:25] = 7'h00;
        if (k == 1) r[31:25] = 7'h20;
        return r;
    endfunction

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SW   = 32'hFE20AE23;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    initial begin
        exp_t e_addi;
        exp_t e_sub;
        exp_t e_sw;
        exp_t q[$];
        logic rdy_exp;
        logic rdy_next;
        logic pop;
        logic acc;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h40;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst.in_ready",  {31'd0, in_ready},    32'd0);
        check("rst.out_valid", {31'd0, out_valid},   32'd0);
        check("rst.pc",        out_pc,               32'd0);
        check("rst.imm",       out_imm,              32'd0);
        check("rst.regs",      {17'd0, out_rd, out_rs1, out_rs2}, 32'd0);
        check("rst.opf3",      {22'd0, out_opcode, out_funct3},   32'd0);
        check("rst.alu_op",    {26'd0, out_alu_op},  32'd18);
        check("rst.illegal",   {31'd0, out_illegal}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("post_rst.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- decode examples ----------------
        e_addi = mk(32'h100, 7'h13, 3'd0, 10, 1, 0, 0, 32'h5, 1'b0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h100;
        tick();
        in_valid = 1'b0;
        check_out("addi", e_addi);

        in_valid = 1'b1; in_instr = I_SUB; in_pc = 32'h104;
        tick();
        e_sub = mk(32'h104, 7'h33, 3'd0, 1, 3, 1, 2, 32'h0, 1'b0);
        check_out("sub", e_sub);
        in_instr = I_SW; in_pc = 32'h108;
        tick();
        e_sw = mk(32'h108, 7'h23, 3'd2, 0, 0, 1, 2, 32'hFFFFFFFC, 1'b0);
        check_out("sw", e_sw);

        in_instr = I_BAD; in_pc = 32'h10C;
        tick();
        check_out("illegal", mk(32'h10C, 7'h7F, 3'd7, 18, 0, 0, 0, 32'h0, 1'b1));
        in_instr = I_ADDI; in_pc = 32'h110;
        tick();
        in_valid = 1'b0;
        check_out("after_illegal", mk(32'h110, 7'h13, 3'd0, 10, 1, 0, 0, 32'h5, 1'b0));
        tick();
        check("drained.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- backpressure A, B, C ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h200;
        tick();
        check("bp.A.in_ready", {31'd0, in_ready}, 32'd1);
        check_out("bp.A_held0", mk(32'h200, 7'h13, 3'd0, 10, 1, 0, 0, 32'h5, 1'b0));
        in_instr = I_SUB; in_pc = 32'h204;
        tick();
        check("bp.B.in_ready", {31'd0, in_ready}, 32'd0);
        check_out("bp.A_held1", mk(32'h200, 7'h13, 3'd0, 10, 1, 0, 0, 32'h5, 1'b0));
        in_instr = I_SW; in_pc = 32'h208;
        tick();
        check("bp.C_held.in_ready", {31'd0, in_ready}, 32'd0);
        check_out("bp.A_held2", mk(32'h200, 7'h13, 3'd0, 10, 1, 0, 0, 32'h5, 1'b0));
        out_ready = 1'b1;
        tick();
        check_out("bp.B", mk(32'h204, 7'h33, 3'd0, 1, 3, 1, 2, 32'h0, 1'b0));
        check("bp.B.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("bp.C", mk(32'h208, 7'h23, 3'd2, 0, 0, 1, 2, 32'hFFFFFFFC, 1'b0));
        tick();
        check("bp.end.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- flush with both slots full ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h300;
        tick();
        in_instr = I_SUB; in_pc = 32'h304;
        tick();
        check("fl.full.in_ready", {31'd0, in_ready}, 32'd0);
        in_instr = I_SW; in_pc = 32'h308; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl.out_valid", {31'd0, out_valid}, 32'd0);
        check("fl.in_ready",  {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();
        check("fl.later0.out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("fl.later1.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- reset mid-transfer ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h400;
        tick();
        in_instr = I_SUB; in_pc = 32'h404;
        tick();
        out_ready = 1'b1; in_instr = I_SW; in_pc = 32'h408; rst = 1'b1;
        tick();
        check("mrst.out_valid", {31'd0, out_valid},  32'd0);
        check("mrst.in_ready",  {31'd0, in_ready},   32'd0);
        check("mrst.alu_op",    {26'd0, out_alu_op}, 32'd18);
        check("mrst.pc",        out_pc,              32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("mrst.after.in_ready",  {31'd0, in_ready},  32'd1);
        check("mrst.after.out_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- randomized run against queue model ----------------
        rdy_exp = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd.in_ready",  {31'd0, in_ready},  {31'd0, rdy_exp});
            check("rnd.out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) check_out("rnd", q[0]);

            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ((cyc % 200) < 100) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 250) == 0) && !rst;

            if (rst) begin
                q.delete();
                rdy_next = 1'b0;
            end else if (flush) begin
                q.delete();
                rdy_next = 1'b1;
            end else begin
                pop = (q.size() > 0) && out_ready;
                acc = in_valid && rdy_exp;
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(in_instr, in_pc));
                rdy_next = (q.size() < 2);
            end
            rdy_exp = rdy_next;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
